// File: rtl/stage_memory_pkg.sv
// Shared definitions for the memory stage: access width encodings, the bus
// FSM state type and the byte-mask helper.
// Optional feature macro: MEM_MISALIGN_SPLIT_EN. When it is defined, accesses
// that cross a word boundary run as two bus beats. Otherwise they fault.
package stage_memory_pkg;

   localparam logic [1:0] MEMW_BYTE = 2'd0;
   localparam logic [1:0] MEMW_HALF = 2'd1;
   localparam logic [1:0] MEMW_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } mem_state_e;

   // Byte mask for an access width. The reserved encoding behaves as a word.
   function automatic logic [3:0] mem_mask(input logic [1:0] width);
      case (width)
         MEMW_BYTE: mem_mask = 4'h1;
         MEMW_HALF: mem_mask = 4'h3;
         default:   mem_mask = 4'hF;
      endcase
   endfunction

endpackage

// File: rtl/stage_memory_if.sv
// Data-bus interface between the memory stage (master) and the bus (slave).
// Handshake: the master holds dbus_req and all request fields stable until a
// cycle in which dbus_ack is high. That cycle completes the beat, and
// dbus_rdata/dbus_err are valid only in that cycle. dbus_ack is ignored when
// dbus_req is low. The master may drop an unacknowledged request only on reset.
interface stage_memory_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [29:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic        dbus_err;
   logic [31:0] dbus_rdata;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      input  dbus_ack, dbus_err, dbus_rdata
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      output dbus_ack, dbus_err, dbus_rdata
   );
endinterface

// File: rtl/stage_memory_align.sv
// Byte-lane alignment for the memory stage. It produces the 8-lane byte
// enables and store data for a two-word window, and the width-truncated,
// extended load value taken from a 64-bit read window.
module stage_memory_align
   import stage_memory_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  off,
   input  logic        extend,
   input  logic [31:0] store_data,
   input  logic [63:0] rwin,
   output logic [7:0]  be64,
   output logic [63:0] wd64,
   output logic [31:0] load_data
);

   logic [63:0] shifted;
   logic [5:0]  bit_off;

   assign bit_off = {1'b0, off, 3'b000};
   assign be64    = {4'h0, mem_mask(width)} << off;
   assign wd64    = {32'h0, store_data} << bit_off;
   assign shifted = rwin >> bit_off;

   // Truncate the shifted window to the access width and extend it.
   always_comb begin
      load_data = shifted[31:0];
      case (width)
         MEMW_BYTE: load_data = {{24{extend & shifted[7]}}, shifted[7:0]};
         MEMW_HALF: load_data = {{16{extend & shifted[15]}}, shifted[15:0]};
         default:   load_data = shifted[31:0];
      endcase
   end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage. It runs the data-bus handshake for loads and stores,
// aligns and extends load data, and registers the result into the write stage.
// Optional feature macro: MEM_MISALIGN_SPLIT_EN. With it, word-crossing
// accesses use a LO then HI beat. Without it, they fault in the first cycle.
module stage_memory
   import stage_memory_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   mem_valid,
   input  logic [31:0]            mem_pc,
   input  logic [31:0]            mem_data0,
   input  logic [31:0]            mem_data1,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic                   mem_extend,
   input  logic [1:0]             mem_width,
   input  logic [4:0]             wb_reg,
   stage_memory_if.master         dbus,
   output logic                   mem_stall,
   output logic [31:0]            mem_forward_data,
   output logic                   wb_valid,
   output logic [31:0]            wb_pc,
   output logic [31:0]            wb_data,
   output logic [4:0]             wb_reg_r,
   output logic                   wb_exc,
   output mem_state_e             dbg_state
);

   mem_state_e  state_q, state_d;
   logic [31:0] lo_q, lo_d;
   logic        wb_valid_q, wb_valid_d;
   logic [31:0] wb_pc_q, wb_pc_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [4:0]  wb_reg_q, wb_reg_d;
   logic        wb_exc_q, wb_exc_d;

   logic        acc, split, misalign_fault, beat_hi, req, ack_ok;
   logic        bus_fault, fault_now, final_ack;
   logic [7:0]  be64;
   logic [63:0] wd64, rwin;
   logic [31:0] load_data;

   assign acc     = mem_valid & (mem_read | mem_write);
   assign beat_hi = (state_q == ST_HI);

   // In the HI beat the low word comes from the capture register.
   assign rwin = beat_hi ? {dbus.dbus_rdata, lo_q} : {32'h0, dbus.dbus_rdata};

   stage_memory_align u_align (
      .width      (mem_width),
      .off        (mem_data0[1:0]),
      .extend     (mem_extend),
      .store_data (mem_data1),
      .rwin       (rwin),
      .be64       (be64),
      .wd64       (wd64),
      .load_data  (load_data)
   );

   assign split = |be64[7:4];
`ifdef MEM_MISALIGN_SPLIT_EN
   assign misalign_fault = 1'b0;
`else
   assign misalign_fault = split;
`endif

   // Reset gates the request so it drops immediately, even with inputs held.
   assign req       = reset_n & acc & ~misalign_fault;
   assign ack_ok    = req & dbus.dbus_ack;
   assign bus_fault = ack_ok & dbus.dbus_err;
   assign fault_now = (acc & misalign_fault) | bus_fault;
   assign final_ack = ack_ok & ~dbus.dbus_err & (beat_hi | ~split);
   assign mem_stall = acc & ~final_ack & ~fault_now;

   assign dbus.dbus_req   = req;
   assign dbus.dbus_we    = req & mem_write;
   assign dbus.dbus_addr  = mem_data0[31:2] + {29'h0, beat_hi};
   assign dbus.dbus_be    = beat_hi ? be64[7:4] : be64[3:0];
   assign dbus.dbus_wdata = beat_hi ? wd64[63:32] : wd64[31:0];

   assign mem_forward_data = fault_now ? 32'h0 : (mem_read ? load_data : mem_data0);

   // Next-state, low-beat capture and write-stage register inputs.
   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE, ST_LO: begin
            if (ack_ok) begin
               lo_d    = dbus.dbus_rdata;
               state_d = (split & ~dbus.dbus_err) ? ST_HI : ST_IDLE;
            end else if (req) begin
               state_d = ST_LO;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HI: begin
            if (ack_ok || !req) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      wb_valid_d = mem_valid & ~mem_stall;
      wb_pc_d    = mem_pc;
      wb_data_d  = mem_forward_data;
      wb_reg_d   = fault_now ? 5'd0 : wb_reg;
      wb_exc_d   = fault_now;
   end

   // Bus FSM, low-beat capture and write-stage register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         lo_q       <= 32'h0;
         wb_valid_q <= 1'b0;
         wb_pc_q    <= 32'h0;
         wb_data_q  <= 32'h0;
         wb_reg_q   <= 5'd0;
         wb_exc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         wb_valid_q <= wb_valid_d;
         wb_pc_q    <= wb_pc_d;
         wb_data_q  <= wb_data_d;
         wb_reg_q   <= wb_reg_d;
         wb_exc_q   <= wb_exc_d;
      end
   end

   assign wb_valid  = wb_valid_q;
   assign wb_pc     = wb_pc_q;
   assign wb_data   = wb_data_q;
   assign wb_reg_r  = wb_reg_q;
   assign wb_exc    = wb_exc_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory. A driver issues one instruction at a time and acts
// as the bus responder. It backs the bus with a byte-addressed memory model,
// and it pushes the expected write-stage result into exp_q. A monitor pops
// and compares every wb_valid cycle.
module tb_stage_memory;
   import stage_memory_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        exc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_pc = 32'h0, mem_data0 = 32'h0, mem_data1 = 32'h0;
   logic        mem_read = 1'b0, mem_write = 1'b0, mem_extend = 1'b0;
   logic [1:0]  mem_width = 2'd0;
   logic [4:0]  wb_reg = 5'd0;
   logic        mem_stall, wb_valid, wb_exc;
   logic [31:0] mem_forward_data, wb_pc, wb_data;
   logic [4:0]  wb_reg_r;
   mem_state_e  dbg_state;

   stage_memory_if dbus ();

   exp_t        exp_q[$];
   logic [7:0]  mem_bytes [logic [31:0]];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          split_en;

   stage_memory dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mem_valid        (mem_valid),
      .mem_pc           (mem_pc),
      .mem_data0        (mem_data0),
      .mem_data1        (mem_data1),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_extend       (mem_extend),
      .mem_width        (mem_width),
      .wb_reg           (wb_reg),
      .dbus             (dbus.master),
      .mem_stall        (mem_stall),
      .mem_forward_data (mem_forward_data),
      .wb_valid         (wb_valid),
      .wb_pc            (wb_pc),
      .wb_data          (wb_data),
      .wb_reg_r         (wb_reg_r),
      .wb_exc           (wb_exc),
      .dbg_state        (dbg_state)
   );

   // Clock and reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] get_byte(input logic [31:0] a);
      if (mem_bytes.exists(a)) return mem_bytes[a];
      return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] get_word(input logic [29:0] wa);
      logic [31:0] b;
      b = {wa, 2'b00};
      return {get_byte(b + 3), get_byte(b + 2), get_byte(b + 1), get_byte(b)};
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      for (int i = 0; i < 4; i++) mem_bytes[a + i] = v[8*i +: 8];
   endtask

   // Driver: issue one instruction, respond on the bus, check handshake.
   task automatic do_instr(input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] sdata, input bit rd, input bit wr,
                           input bit ext, input logic [1:0] width, input logic [4:0] rdreg,
                           input int lat, input int err_beat);
      int          n, nbeats, beat, waitc;
      bit          misfault, busfault, done, fin, ack;
      logic [31:0] ld, lane_m, a;
      logic [3:0]  exp_be [2];
      logic [31:0] exp_wd [2];
      exp_t        e;
      n = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
      misfault = (rd || wr) && (int'(addr[1:0]) + n > 4) && !split_en;
      nbeats = !(rd || wr) ? 0 : (int'(addr[1:0]) + n > 4) ? 2 : 1;
      busfault = !misfault && err_beat < nbeats;
      exp_be[0] = 4'h0; exp_be[1] = 4'h0; exp_wd[0] = 32'h0; exp_wd[1] = 32'h0;
      ld = 32'h0;
      for (int i = 0; i < n; i++) begin
         a = addr + i;
         exp_be[a[31:2] - addr[31:2]][a[1:0]] = 1'b1;
         exp_wd[a[31:2] - addr[31:2]][8*a[1:0] +: 8] = sdata[8*i +: 8];
         ld[8*i +: 8] = get_byte(a);
      end
      if (ext && n == 1) ld = {{24{ld[7]}}, ld[7:0]};
      if (ext && n == 2) ld = {{16{ld[15]}}, ld[15:0]};
      e.pc = pc;
      e.exc = misfault || busfault;
      e.data = e.exc ? 32'h0 : (rd ? ld : addr);
      e.rd = e.exc ? 5'd0 : rdreg;
      exp_q.push_back(e);
      mem_valid = 1'b1; mem_pc = pc; mem_data0 = addr; mem_data1 = sdata;
      mem_read = rd; mem_write = wr; mem_extend = ext; mem_width = width; wb_reg = rdreg;
      beat = 0; waitc = 0; done = 0;
      for (int cyc = 0; cyc < 32 && !done; cyc++) begin
         @(negedge clk);
         ack = 0; fin = 0;
         if (nbeats > 0 && !misfault) begin
            chk("dbus_req", {31'h0, dbus.dbus_req}, 32'h1);
            chk("dbus_addr", {2'b00, dbus.dbus_addr}, addr[31:2] + beat);
            chk("dbus_be", {28'h0, dbus.dbus_be}, {28'h0, exp_be[beat]});
            chk("dbus_we", {31'h0, dbus.dbus_we}, {31'h0, wr});
            if (wr) begin
               for (int l = 0; l < 4; l++) lane_m[8*l +: 8] = {8{exp_be[beat][l]}};
               chk("dbus_wdata", dbus.dbus_wdata & lane_m, exp_wd[beat]);
            end
            if (waitc == lat) begin
               ack = 1;
               fin = (beat == err_beat) || (beat == nbeats - 1);
               dbus.dbus_ack = 1'b1;
               dbus.dbus_err = (beat == err_beat);
               dbus.dbus_rdata = get_word(addr[31:2] + beat);
            end
         end else begin
            chk("dbus_req_idle", {31'h0, dbus.dbus_req}, 32'h0);
            fin = 1;
         end
         #1;
         chk("mem_stall", {31'h0, mem_stall}, {31'h0, !fin});
         if (fin) chk("forward", mem_forward_data, e.data);
         @(posedge clk);
         #1;
         dbus.dbus_ack = 1'b0; dbus.dbus_err = 1'b0; dbus.dbus_rdata = $urandom;
         if (fin) done = 1;
         else if (ack) begin beat++; waitc = 0; end
         else waitc++;
      end
      if (!done) chk("timeout", 32'h0, 32'h1);
      mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // Monitor: compare every write-stage output against the expected queue.
   always @(negedge clk) begin
      if (reset_n && wb_valid) begin
         if (exp_q.size() == 0) chk("unexpected_wb_valid", 32'h1, 32'h0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_pc", wb_pc, e.pc);
            chk("wb_data", wb_data, e.data);
            chk("wb_reg_r", {27'h0, wb_reg_r}, {27'h0, e.rd});
            chk("wb_exc", {31'h0, wb_exc}, {31'h0, e.exc});
         end
      end
   end

   initial begin
`ifdef MEM_MISALIGN_SPLIT_EN
      split_en = 1'b1;
`else
      split_en = 1'b0;
`endif
      dbus.dbus_ack = 1'b0; dbus.dbus_err = 1'b0; dbus.dbus_rdata = 32'h0;
      #3;
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_pc", wb_pc, 32'h0);
      chk("rst_wb_reg_r", {27'h0, wb_reg_r}, 32'h0);
      chk("rst_wb_exc", {31'h0, wb_exc}, 32'h0);
      chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
      chk("rst_stall", {31'h0, mem_stall}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // Zero-wait LW
      set_word(32'h100, 32'hDEADBEEF);
      do_instr(32'h1000, 32'h100, 32'h0, 1, 0, 0, MEMW_WORD, 5'd3, 0, 9);
      // LB/LBU at 0x103 with two wait cycles
      set_word(32'h100, 32'h80000000);
      do_instr(32'h1004, 32'h103, 32'h0, 1, 0, 1, MEMW_BYTE, 5'd4, 2, 9);
      do_instr(32'h1008, 32'h103, 32'h0, 1, 0, 0, MEMW_BYTE, 5'd5, 2, 9);
      // SH at 0x202
      do_instr(32'h100C, 32'h202, 32'h1234ABCD, 0, 1, 0, MEMW_HALF, 5'd0, 1, 9);
      // Misaligned LW at 0x301
      set_word(32'h300, 32'h44332211);
      set_word(32'h304, 32'h88776655);
      do_instr(32'h1010, 32'h301, 32'h0, 1, 0, 0, MEMW_WORD, 5'd6, 0, 9);
      do_instr(32'h1014, 32'h301, 32'h0, 1, 0, 0, MEMW_WORD, 5'd6, 1, 9);
      // Bus error on a load, then an ALU instruction
      do_instr(32'h1018, 32'h100, 32'h0, 1, 0, 0, MEMW_WORD, 5'd7, 1, 0);
      chk("state_after_err", {30'h0, dbg_state}, {30'h0, ST_IDLE});
      do_instr(32'h101C, 32'h55AA, 32'h0, 0, 0, 0, MEMW_WORD, 5'd8, 0, 9);

      // Stray ack with no request is ignored
      dbus.dbus_ack = 1'b1;
      @(posedge clk); #1;
      dbus.dbus_ack = 1'b0;
      chk("stray_ack_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});

      // Reset while waiting in LO
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_data0 = 32'h100;
      mem_width = MEMW_WORD; wb_reg = 5'd9; mem_pc = 32'h1020;
      @(posedge clk); #1;
      chk("lo_req", {31'h0, dbus.dbus_req}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_req", {31'h0, dbus.dbus_req}, 32'h0);
      chk("rst_mid_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_mid_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
      mem_valid = 1'b0; mem_read = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_instr(32'h1024, 32'h100, 32'h0, 1, 0, 0, MEMW_WORD, 5'd9, 1, 9);

      // Randomized mix of loads, stores and ALU instructions
      for (int k = 0; k < 60; k++) begin
         int    kind;
         bit    r, w;
         logic [31:0] ad;
         kind = $urandom_range(0, 2);
         r = (kind == 0);
         w = (kind == 1);
         ad = {24'h0, 8'($urandom_range(0, 255))};
         do_instr(32'h2000 + 4 * k, ad, $urandom, r, w, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), w ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : 9);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("exp_q_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result / effective address, store data and load/store controls, and runs the data-bus handshake.
- Aligns and extends load data, then registers the result, rd and PC into the write stage.
- Drives mem_stall back to execute while a bus access is outstanding.

Parameters:
- (none)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
mem_valid  in  1  instruction valid in this stage
mem_pc  in  32  PC of instruction
mem_data0  in  32  ALU result; effective address for loads/stores
mem_data1  in  32  store data (rs2)
mem_read  in  1  load
mem_write  in  1  store
mem_extend  in  1  1 = sign-extend load, 0 = zero-extend
mem_width  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
wb_reg  in  5  destination register
dbus_ack  in  1  bus completes current beat this cycle
dbus_err  in  1  bus error; qualified by dbus_ack
dbus_rdata  in  32  read data; valid with dbus_ack
dbus_req  out  1  bus request
dbus_we  out  1  write enable
dbus_addr  out  30  word address, byte address [31:2]
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-shifted store data
mem_stall  out  1  hold execute and the inputs of this stage
mem_forward_data  out  32  result of this stage for the forwarding unit
wb_valid  out  1  write-stage valid
wb_pc  out  32  registered PC
wb_data  out  32  load result or passthrough ALU result
wb_reg_r  out  5  registered rd (0 on fault)
wb_exc  out  1  access fault (bus error or misaligned)

Behaviour:
- Reset: all registered outputs are 0; FSM goes to IDLE.
- Access definition: acc = mem_valid & (mem_read | mem_write). The other ports (mem_data0, mem_data1, mem_pc, controls) are stable while mem_stall is high, because execute holds its registers.
- FSM states: IDLE, LO, HI.
  - IDLE: if acc and not faulted, dbus_req = 1 in the same cycle (combinational).
  - Ack in the same cycle: the access completes with zero wait states.
  - No ack: go to LO.
  - Split access needs a second beat: go to HI instead of completing.
  - LO: hold the request until dbus_ack. Then go to HI if split, else back to IDLE.
  - HI: request the word at address + 4. On dbus_ack, go to IDLE.
- Byte lanes: off = mem_data0[1:0]. mask is 1, 3 or F for byte, half or word. be64 = mask << off; wd64 = mem_data1 << 8*off.
  - Beat 0: dbus_addr = mem_data0[31:2], dbus_be = be64[3:0], dbus_wdata = wd64[31:0].
  - Beat 1: dbus_addr + 1, dbus_be = be64[7:4], dbus_wdata = wd64[63:32].
- Load data: the low beat's rdata is captured in an internal register. The combined value is {hi, lo} >> 8*off, truncated to the access width, then sign- or zero-extended per mem_extend.
- Stall: mem_stall = acc & ~(final beat acked this cycle) & ~fault_now.
  - Never asserted for a non-memory instruction.
  - Never asserted when mem_valid = 0.
- Write-stage register: updates every cycle; wb_valid <= mem_valid & ~mem_stall.
  - wb_data: load result for loads, otherwise mem_data0 (stores write no rd; wb_reg is 0 from decode).
- Forwarding: mem_forward_data equals the value that wb_data will take on the next edge. It is meaningful only when mem_stall = 0.
- Bus error: dbus_err with dbus_ack on any beat gives fault.
  - Remaining beats are abandoned and the FSM returns to IDLE.
  - wb_exc = 1, wb_data = 0, wb_reg_r = 0.
- Reset mid-access: the FSM returns to IDLE immediately and dbus_req drops. The bus must tolerate an abandoned request.
- dbus_ack arriving while dbus_req = 0 is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_SPLIT_EN.
- Defined: an access with be64[7:4] != 0 (crosses a word boundary) is executed as two beats, LO then HI. Half-word at off = 3 and word at off != 0 are split.
- Not defined: such an access is a fault in the first cycle. No dbus_req is issued, and mem_stall stays 0 for that instruction (fault_now). The result is wb_exc = 1 and wb_reg_r = 0. The HI state is unreachable.

Decomposition:
- Add a shared package (name it in the defines header) holding:
  - MEMW_BYTE/HALF/WORD width encodings
  - FSM state typedef (IDLE/LO/HI)
  - function mem_mask(width)
- Natural sub-module: mem_align, purely combinational. It takes width, off, extend, and the 64-bit read window, and produces be64, wd64 and the extended load data. Reuse it in the bench as a reference model.

Test Plan:
- Zero-wait LW from addr 0x100, dbus_ack same cycle, rdata 0xDEADBEEF:
  - dbus_addr = 0x40, be = F.
  - No stall.
  - Next cycle wb_valid = 1, wb_data = 0xDEADBEEF.
- LB sign-extend at 0x103, 2-cycle ack latency, rdata 0x80000000:
  - be = 8.
  - mem_stall high for 2 cycles, req held.
  - wb_data = 0xFFFFFF80; LBU gives 0x00000080.
- SH data 0x1234ABCD at 0x202:
  - be = C, wdata = 0xABCD0000, we = 1.
  - wb_reg_r = 0.
- Misaligned LW at 0x301, lo rdata 0x44332211, hi 0x88776655:
  - With MEM_MISALIGN_SPLIT_EN: two beats (be E then 1), wb_data = 0x55443322.
  - Without it: no dbus_req, no stall, wb_exc = 1.
- dbus_err on a load:
  - wb_exc = 1, wb_data = 0, wb_reg_r = 0, FSM back to IDLE.
  - A following ALU instruction passes with no stall.
- reset_n low while in LO:
  - dbus_req drops asynchronously and wb_valid = 0.
  - After release, a new access starts from IDLE correctly.
